prv_trap_ctrl: RTL

- Multi-lane trap/return sequencer between a superscalar (NUM_LANES-wide) commit stage and the machine-mode priv block.
- Each cycle it selects the oldest excepting, returning or interruptible lane and squashes younger lanes.
- Holds a registered trap request until the priv block acknowledges its CSR update, then issues a one-cycle PC redirect (direct or vectored xtvec).
- Generalises the single-lane hazard-to-priv exception path to N lanes, a vectored mode, and an explicit request/acknowledge handshake.

---
 rtl/prv_trap_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/prv_trap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prv_trap_ctrl: multi-lane trap/mret sequencer between commit & priv   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module prv_trap_ctrl #(
    parameter  int NUM_LANES = 2,
    parameter  int XLEN      = 32,
    parameter  int NUM_EXT   = 4,
    localparam int RW        = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1,
    localparam int LW        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic [NUM_LANES-1:0]      lane_valid,
    input  logic [NUM_LANES*10-1:0]   lane_exc,
    input  logic [NUM_LANES-1:0]      lane_ret,
    input  logic [NUM_LANES*XLEN-1:0] lane_pc,
    input  logic [NUM_LANES*XLEN-1:0] lane_badaddr,
    input  logic [NUM_LANES*RW-1:0]   lane_rmgmt_cause,
    input  logic                      ext_int,
    input  logic                      soft_int,
    input  logic                      timer_int,
    input  logic [XLEN-1:0]           xtvec,
    input  logic [XLEN-1:0]           xepc_r,
    input  logic                      priv_ack,
    output logic                      trap_req,
    output logic                      intr,
    output logic [5:0]                cause,
    output logic [XLEN-1:0]           epc,
    output logic [XLEN-1:0]           badaddr,
    output logic                      ret,
    output logic [NUM_LANES-1:0]      lane_kill,
    output logic                      pipe_clear,
    output logic                      insert_pc,
    output logic [XLEN-1:0]           priv_pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        REDIR = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              intr_q, intr_d;
    logic [5:0]        cause_q, cause_d;
    logic [XLEN-1:0]   epc_q, epc_d;
    logic [XLEN-1:0]   badaddr_q, badaddr_d;
    logic              ret_q, ret_d;
    logic [XLEN-1:0]   priv_pc_q, priv_pc_d;

    logic              sel_found;
    logic              sel_is_exc;
    logic [LW-1:0]     sel_lane;
    logic [5:0]        sel_cause;
    logic              int_take;
    logic [5:0]        int_cause;
    logic [XLEN-1:0]   tvec_base;
    logic [XLEN-1:0]   trap_target;

    // Flag order low to high is also the in-lane priority order.
    function automatic logic [5:0] exc_cause(input logic [9:0] f, input logic [RW-1:0] r);
        logic [5:0] c;
        c = 6'd0;
        if      (f[0]) c = 6'd1;
        else if (f[1]) c = 6'd0;
        else if (f[2]) c = 6'd2;
        else if (f[3]) c = 6'd3;
        else if (f[4]) c = 6'd11;
        else if (f[5]) c = 6'd4;
        else if (f[6]) c = 6'd6;
        else if (f[7]) c = 6'd5;
        else if (f[8]) c = 6'd7;
        else if (f[9]) c = 6'd24 + 6'(r);
        return c;
    endfunction

    always_comb begin
        sel_found  = 1'b0;
        sel_is_exc = 1'b0;
        sel_lane   = '0;
        sel_cause  = 6'd0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (!sel_found && lane_valid[i] && ((|lane_exc[i*10 +: 10]) || lane_ret[i])) begin
                sel_found  = 1'b1;
                sel_is_exc = |lane_exc[i*10 +: 10];
                sel_lane   = LW'(i);
                sel_cause  = exc_cause(lane_exc[i*10 +: 10], lane_rmgmt_cause[i*RW +: RW]);
            end
        end
    end

    assign int_take  = !sel_found && lane_valid[0] && (ext_int || soft_int || timer_int);
    assign int_cause = ext_int ? 6'd11 : (soft_int ? 6'd3 : 6'd7);

    always_comb begin
        lane_kill = '0;
        if (state_q == IDLE) begin
            for (int j = 0; j < NUM_LANES; j++) begin
                if (int_take)
                    lane_kill[j] = 1'b1;
                else if (sel_found && sel_is_exc && j >= int'(sel_lane))
                    lane_kill[j] = 1'b1;
                else if (sel_found && !sel_is_exc && j > int'(sel_lane))
                    lane_kill[j] = 1'b1;
            end
        end
    end

    // Vectored mode only offsets interrupts; exceptions always use the base.
    assign tvec_base   = {xtvec[XLEN-1:2], 2'b00};
    assign trap_target = (xtvec[1:0] == 2'b01 && intr_q)
                         ? tvec_base + XLEN'({cause_q, 2'b00}) : tvec_base;

    always_comb begin
        state_d   = state_q;
        intr_d    = intr_q;
        cause_d   = cause_q;
        epc_d     = epc_q;
        badaddr_d = badaddr_q;
        ret_d     = 1'b0;
        priv_pc_d = priv_pc_q;
        case (state_q)
            IDLE: begin
                if (sel_found && sel_is_exc) begin
                    state_d   = REQ;
                    intr_d    = 1'b0;
                    cause_d   = sel_cause;
                    epc_d     = lane_pc[sel_lane*XLEN +: XLEN];
                    badaddr_d = lane_badaddr[sel_lane*XLEN +: XLEN];
                end else if (sel_found) begin
                    state_d   = REDIR;
                    ret_d     = 1'b1;
                    priv_pc_d = xepc_r;
                end else if (int_take) begin
                    state_d   = REQ;
                    intr_d    = 1'b1;
                    cause_d   = int_cause;
                    epc_d     = lane_pc[0 +: XLEN];
                    badaddr_d = '0;
                end
            end
            REQ: begin
                if (priv_ack) begin
                    state_d   = REDIR;
                    priv_pc_d = trap_target;
                end
            end
            REDIR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            intr_q    <= 1'b0;
            cause_q   <= 6'd0;
            epc_q     <= '0;
            badaddr_q <= '0;
            ret_q     <= 1'b0;
            priv_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            intr_q    <= intr_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
            badaddr_q <= badaddr_d;
            ret_q     <= ret_d;
            priv_pc_q <= priv_pc_d;
        end
    end

    assign trap_req   = (state_q == REQ);
    assign insert_pc  = (state_q == REDIR);
    assign pipe_clear = (state_q == REQ) || (state_q == REDIR);
    assign intr       = intr_q;
    assign cause      = cause_q;
    assign epc        = epc_q;
    assign badaddr    = badaddr_q;
    assign ret        = ret_q;
    assign priv_pc    = priv_pc_q;

endmodule
`default_nettype wire
